// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between decode and the immediate generator.
// The generator uses the slave view; whoever feeds and drains it uses master.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       fmt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport slave (
    input  in_valid, instr, fmt, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport master (
    output in_valid, instr, fmt, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator with a main output register and a
// one-entry skid register, so in_ready comes straight from a flop.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  imm_gen_pipe_if.slave io_bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  // Builds a 64-bit sign/zero-extended immediate and trims it to XLEN.
  function automatic logic [XLEN-1:0] f_imm(input logic [31:0] ins, input logic [2:0] f);
    logic [63:0] v;
    v = 64'd0;
    case (f)
      3'd0:    v = {{52{ins[31]}}, ins[31:20]};
      3'd1:    v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2:    v = {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3:    v = {{32{ins[31]}}, ins[31:12], 12'd0};
      3'd4:    v = {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd5: begin
        if (XLEN == 32) v = {59'd0, ins[24:20]};
        else            v = {58'd0, ins[25:20]};
      end
      default: v = 64'd0;
    endcase
    return v[XLEN-1:0];
  endfunction

  entry_t r_m;
  entry_t r_s;
  logic   r_m_valid;
  logic   r_s_valid;
  entry_t w_new;
  logic   w_accept;
  logic   w_unused_opcode;

  assign w_unused_opcode = ^io_bus.instr[6:0];

  assign w_new.imm = f_imm(io_bus.instr, io_bus.fmt);
  assign w_new.tag = io_bus.in_tag;
  assign w_new.ill = (io_bus.fmt == 3'd6) || (io_bus.fmt == 3'd7);
  assign w_accept  = io_bus.in_valid && !r_s_valid;

  // Main/skid storage: skid drains first, so it is never refilled while full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m       <= '0;
      r_s       <= '0;
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (r_s_valid) begin
      if (io_bus.out_ready) begin
        r_m       <= r_s;
        r_s_valid <= 1'b0;
      end else begin
        r_s_valid <= 1'b1;
      end
    end else if (w_accept) begin
      if (!r_m_valid || io_bus.out_ready) begin
        r_m       <= w_new;
        r_m_valid <= 1'b1;
      end else begin
        r_s       <= w_new;
        r_s_valid <= 1'b1;
      end
    end else if (io_bus.out_ready) begin
      r_m_valid <= 1'b0;
    end else begin
      r_m_valid <= r_m_valid;
    end
  end

  assign io_bus.in_ready    = !r_s_valid;
  assign io_bus.out_valid   = r_m_valid;
  assign io_bus.out_imm     = r_m.imm;
  assign io_bus.out_tag     = r_m.tag;
  assign io_bus.out_illegal = r_m.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives identical traffic into XLEN=32 and XLEN=64 instances and checks both
// against a queue-based model of the immediate rules and FIFO behaviour.
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      instr;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } item_t;

  logic clk = 1'b0;
  logic tb_rst = 1'b1;
  logic tb_valid = 1'b0;
  logic [31:0] tb_instr = 32'd0;
  logic [2:0] tb_fmt = 3'd0;
  logic [TAG_W-1:0] tb_tag = '0;
  logic tb_out_ready = 1'b1;
  bit chk_en = 1'b0;
  int n_checks = 0;
  int n_err = 0;

  item_t q[$];
  item_t last;
  bit last_rst = 1'b1;
  logic [TAG_W-1:0] seen[$];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

  assign bus32.in_valid = tb_valid;  assign bus64.in_valid = tb_valid;
  assign bus32.instr = tb_instr;     assign bus64.instr = tb_instr;
  assign bus32.fmt = tb_fmt;         assign bus64.fmt = tb_fmt;
  assign bus32.in_tag = tb_tag;      assign bus64.in_tag = tb_tag;
  assign bus32.out_ready = tb_out_ready;
  assign bus64.out_ready = tb_out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.i_clk(clk), .i_rst(tb_rst), .io_bus(bus32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.i_clk(clk), .i_rst(tb_rst), .io_bus(bus64.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Immediate rules written as signed-integer arithmetic on the instruction word.
  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] f, input int xlen);
    longint si;
    longint r;
    si = longint'($signed(ins));
    case (f)
      3'd0: r = si >>> 20;
      3'd1: r = ((si >>> 25) <<< 5) + longint'(ins[11:7]);
      3'd2: r = ((si >>> 31) <<< 12) + (longint'(ins[7]) << 11)
              + (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
      3'd3: r = (si >>> 12) <<< 12;
      3'd4: r = ((si >>> 31) <<< 20) + (longint'(ins[19:12]) << 12)
              + (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
      3'd5: r = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
      default: r = 0;
    endcase
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  // Compare on the falling edge, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    item_t e;
    bit z;
    if (q.size() > 0) begin e = q[0]; z = 1'b0; end
    else begin e = last; z = last_rst; end
    if (chk_en) begin
      chk("in_ready32", 64'(bus32.in_ready), 64'(q.size() < 2));
      chk("in_ready64", 64'(bus64.in_ready), 64'(q.size() < 2));
      chk("out_valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
      chk("out_valid64", 64'(bus64.out_valid), 64'(q.size() > 0));
      chk("imm32", 64'(bus32.out_imm), z ? 64'd0 : model_imm(e.instr, e.fmt, 32));
      chk("imm64", 64'(bus64.out_imm), z ? 64'd0 : model_imm(e.instr, e.fmt, 64));
      chk("tag32", 64'(bus32.out_tag), z ? 64'd0 : 64'(e.tag));
      chk("tag64", 64'(bus64.out_tag), z ? 64'd0 : 64'(e.tag));
      chk("ill32", 64'(bus32.out_illegal), z ? 64'd0 : 64'(e.fmt > 3'd5));
      chk("ill64", 64'(bus64.out_illegal), z ? 64'd0 : 64'(e.fmt > 3'd5));
      if (!tb_rst && bus32.out_valid && tb_out_ready) seen.push_back(bus32.out_tag);
    end
    if (tb_rst) begin
      q.delete();
      last_rst = 1'b1;
    end else begin
      bit pop;
      bit push;
      item_t n;
      pop  = (q.size() > 0) && tb_out_ready;
      push = tb_valid && (q.size() < 2);
      n.instr = tb_instr; n.fmt = tb_fmt; n.tag = tb_tag;
      if (pop) begin last = q.pop_front(); last_rst = 1'b0; end
      if (push) q.push_back(n);
    end
  end

  // Present one entry and hold it until the block takes it.
  task automatic drive(input logic [31:0] ins, input logic [2:0] f, input logic [TAG_W-1:0] t);
    bit got;
    got = 1'b0;
    tb_valid = 1'b1; tb_instr = ins; tb_fmt = f; tb_tag = t;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus32.in_ready;
      @(posedge clk);
      #1;
    end
    tb_valid = 1'b0;
    if (!got) begin
      n_err++;
      n_checks++;
      $display("FAIL accept_timeout tag=%0d never accepted within 50 cycles", t);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_valid"}, 64'(bus32.out_valid | bus64.out_valid), 64'd0);
    chk({name, "_ready"}, 64'(bus32.in_ready & bus64.in_ready), 64'd1);
    chk({name, "_imm32"}, 64'(bus32.out_imm), 64'd0);
    chk({name, "_imm64"}, 64'(bus64.out_imm), 64'd0);
    chk({name, "_tag"}, 64'(bus32.out_tag | bus64.out_tag), 64'd0);
    chk({name, "_ill"}, 64'(bus32.out_illegal | bus64.out_illegal), 64'd0);
  endtask

  logic [31:0] vec_instr [10] = '{32'hFFF00093, 32'h00A12423, 32'hFE0008E3, 32'h12345037,
                                  32'h8000006F, 32'h41F05013, 32'h7FF00013, 32'hFFFFF0B7,
                                  32'h00000000, 32'hFEDCBA98};
  logic [2:0]  vec_fmt   [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd3, 3'd7, 3'd1};
  logic [15:0] rdy_pat = 16'b1011_0010_1110_0101;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    tb_rst = 1'b0;
    chk_en = 1'b1;
    chk_reset_state("reset");

    // Hand-computed immediates pinning the model.
    drive(32'hFFF00093, 3'd0, 5'd7);
    chk("T1_imm32", 64'(bus32.out_imm), 64'hFFFF_FFFF);
    chk("T1_imm64", 64'(bus64.out_imm), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("T1_tag", 64'(bus32.out_tag), 64'd7);
    chk("T1_valid", 64'(bus32.out_valid), 64'd1);
    drive(32'h80000063, 3'd2, 5'd1);
    chk("T2_B_imm32", 64'(bus32.out_imm), 64'hFFFF_F000);
    drive(32'h7FFFF06F, 3'd4, 5'd2);
    chk("T2_J_imm32", 64'(bus32.out_imm), 64'h000F_FFFE);
    drive(32'h800002B7, 3'd3, 5'd3);
    chk("T3_U_imm64", 64'(bus64.out_imm), 64'hFFFF_FFFF_8000_0000);
    chk("T3_U_imm32", 64'(bus32.out_imm), 64'h8000_0000);
    drive(32'h03F00013, 3'd5, 5'd4);
    chk("T3_SH_imm64", 64'(bus64.out_imm), 64'd63);
    chk("T3_SH_imm32", 64'(bus32.out_imm), 64'd31);
    drive(32'h12345678, 3'd6, 5'd5);
    chk("T5_ill", 64'(bus32.out_illegal & bus64.out_illegal), 64'd1);
    chk("T5_imm", 64'(bus32.out_imm | bus64.out_imm), 64'd0);
    drive(32'hFFFFFFFF, 3'd7, 5'd6);
    chk("T5_ill7", 64'(bus64.out_illegal), 64'd1);
    @(posedge clk); #1;
    chk("empty_hold_imm", 64'(bus32.out_imm), 64'd0);
    chk("empty_valid", 64'(bus32.out_valid), 64'd0);

    // Back-to-back stream, then the same stream under a ready pattern.
    for (int i = 0; i < 10; i++) drive(vec_instr[i], vec_fmt[i], 5'(i + 8));
    fork
      begin
        for (int i = 0; i < 10; i++) drive(vec_instr[9 - i], vec_fmt[9 - i], 5'(i + 20));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          tb_out_ready = rdy_pat[c % 16];
          @(posedge clk); #1;
        end
        tb_out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure: two entries fill M and S, then release in order.
    seen.delete();
    tb_out_ready = 1'b0;
    drive(32'h00100093, 3'd0, 5'd1);
    drive(32'h00200113, 3'd0, 5'd2);
    chk("T4_in_ready_full", 64'(bus32.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("T4_hold_tag", 64'(bus32.out_tag), 64'd1);
    chk("T4_hold_imm", 64'(bus32.out_imm), 64'd1);
    fork
      begin repeat (3) @(posedge clk); #1; tb_out_ready = 1'b1; end
      begin drive(32'h00300193, 3'd0, 5'd3); drive(32'h00400213, 3'd0, 5'd4); end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("T4_count", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("T4_order", 64'(seen[i]), 64'(i + 1));

    // Reset with both entries occupied.
    tb_out_ready = 1'b0;
    drive(32'hABCDE0B7, 3'd3, 5'd9);
    drive(32'h55555555, 3'd4, 5'd10);
    chk("T6_full", 64'(bus32.in_ready), 64'd0);
    tb_rst = 1'b1;
    @(posedge clk); #1;
    tb_rst = 1'b0;
    chk_reset_state("T6");
    tb_out_ready = 1'b1;
    drive(32'hFFF00093, 3'd0, 5'd11);
    chk("T6_after_tag", 64'(bus32.out_tag), 64'd11);
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
